// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared lamp encodings and phase state codes
package traffic_pkg;

   localparam logic [2:0] RED    = 3'b100;
   localparam logic [2:0] GREEN  = 3'b010;
   localparam logic [2:0] YELLOW = 3'b001;

   typedef enum logic [2:0] {
      NS_GREEN  = 3'd0,
      NS_YELLOW = 3'd1,
      ALLRED_A  = 3'd2,
      EW_GREEN  = 3'd3,
      EW_YELLOW = 3'd4,
      ALLRED_B  = 3'd5,
      WALK      = 3'd6
   } phase_e;

endpackage

// File: rtl/traffic_phase_controller_timer.sv
// rtl/traffic_phase_controller_timer.sv - loadable down-counter that holds at zero
module phase_timer #(
   parameter int             TW        = 4,
   parameter logic [TW-1:0]  RESET_VAL = '0
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          load,
   input  logic [TW-1:0] load_val,
   output logic          done
);

   logic [TW-1:0] cnt_q, cnt_d;

   // Load wins over counting; an expired count stays at zero until reloaded.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Count register; reset leaves it primed for the reset phase.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= RESET_VAL;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done = (cnt_q == '0);

endmodule

// File: rtl/traffic_phase_controller.sv
// rtl/traffic_phase_controller.sv - two-road phase sequencer with pedestrian walk insertion
module traffic_phase_controller
   import traffic_pkg::*;
#(
   parameter int T_GREEN  = 8,
   parameter int T_YELLOW = 3,
   parameter int T_ALLRED = 2,
   parameter int T_WALK   = 6
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ped_req,
   output logic       ped_ack,
   output logic       walk,
   output logic [2:0] light_ns,
   output logic [2:0] light_ew,
   output logic [2:0] phase
);

   localparam int T_MAX_GY = (T_GREEN > T_YELLOW) ? T_GREEN : T_YELLOW;
   localparam int T_MAX_AW = (T_ALLRED > T_WALK) ? T_ALLRED : T_WALK;
   localparam int T_MAX    = (T_MAX_GY > T_MAX_AW) ? T_MAX_GY : T_MAX_AW;
   localparam int TW       = $clog2(T_MAX) + 1;

   // Timer reload value for the phase about to be entered.
   function automatic logic [TW-1:0] dur_m1(input phase_e s);
      case (s)
         NS_GREEN, EW_GREEN:   dur_m1 = TW'(T_GREEN - 1);
         NS_YELLOW, EW_YELLOW: dur_m1 = TW'(T_YELLOW - 1);
         WALK:                 dur_m1 = TW'(T_WALK - 1);
         default:              dur_m1 = TW'(T_ALLRED - 1);
      endcase
   endfunction

   // Lamp pair {ns, ew}; anything unrecognised shows both RED.
   function automatic logic [5:0] lamps(input phase_e s);
      case (s)
         NS_GREEN:  lamps = {GREEN, RED};
         NS_YELLOW: lamps = {YELLOW, RED};
         EW_GREEN:  lamps = {RED, GREEN};
         EW_YELLOW: lamps = {RED, YELLOW};
         default:   lamps = {RED, RED};
      endcase
   endfunction

   phase_e        state_q, state_d;
   logic          pending_q, pending_d;
   logic          resume_q, resume_d;
   logic          ack_q, ack_d;
   logic          walk_q, walk_d;
   logic [2:0]    ns_q, ns_d, ew_q, ew_d;
   logic          load;
   logic [TW-1:0] load_val;
   logic          timer_done;

   phase_timer #(
      .TW        (TW),
      .RESET_VAL (TW'(T_ALLRED - 1))
   ) u_timer (
      .clock    (clock),
      .reset    (reset),
      .load     (load),
      .load_val (load_val),
      .done     (timer_done)
   );

   // Next phase, pedestrian latch, and registered decode of the next phase.
   always_comb begin
      state_d  = state_q;
      resume_d = resume_q;
      load     = 1'b0;
      case (state_q)
         NS_GREEN:  if (timer_done) state_d = NS_YELLOW;
         NS_YELLOW: if (timer_done) state_d = ALLRED_A;
         EW_GREEN:  if (timer_done) state_d = EW_YELLOW;
         EW_YELLOW: if (timer_done) state_d = ALLRED_B;
         ALLRED_A: begin
            if (timer_done) begin
               if (pending_q) begin
                  state_d  = WALK;
                  resume_d = 1'b1;
               end else begin
                  state_d = EW_GREEN;
               end
            end
         end
         ALLRED_B: begin
            if (timer_done) begin
               if (pending_q) begin
                  state_d  = WALK;
                  resume_d = 1'b0;
               end else begin
                  state_d = NS_GREEN;
               end
            end
         end
         WALK:      if (timer_done) state_d = resume_q ? EW_GREEN : NS_GREEN;
         default: begin
            state_d = ALLRED_B;
            load    = 1'b1;
         end
      endcase
      if (state_d != state_q) load = 1'b1;
      load_val = dur_m1(state_d);

      // Requests are dropped while walking and on the edge that starts the walk.
      if (state_d == WALK) begin
         pending_d = 1'b0;
      end else if (state_q == WALK) begin
         pending_d = pending_q;
      end else begin
         pending_d = pending_q | ped_req;
      end

      {ns_d, ew_d} = lamps(state_d);
      walk_d       = (state_d == WALK);
      ack_d        = (state_d == WALK) && (state_q != WALK);
   end

   // State and output registers; reset parks in the clearance before NS green.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ALLRED_B;
         pending_q <= 1'b0;
         resume_q  <= 1'b0;
         ack_q     <= 1'b0;
         walk_q    <= 1'b0;
         ns_q      <= RED;
         ew_q      <= RED;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         resume_q  <= resume_d;
         ack_q     <= ack_d;
         walk_q    <= walk_d;
         ns_q      <= ns_d;
         ew_q      <= ew_d;
      end
   end

   assign ped_ack  = ack_q;
   assign walk     = walk_q;
   assign light_ns = ns_q;
   assign light_ew = ew_q;
   assign phase    = state_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// tb/tb_traffic_phase_controller.sv - scoreboard bench for traffic_phase_controller
module tb_traffic_phase_controller;

   localparam logic [2:0] NSG = 3'd0, NSY = 3'd1, ARA = 3'd2, EWG = 3'd3;
   localparam logic [2:0] EWY = 3'd4, ARB = 3'd5, WLK = 3'd6;
   localparam logic [2:0] LR = 3'b100, LG = 3'b010, LY = 3'b001;
   localparam logic [31:0] NONE = 32'h0;
   localparam logic [31:0] ALL  = 32'hFFFF_FFFF;

   typedef struct packed {
      logic [2:0] ph;
      logic [2:0] ns;
      logic [2:0] ew;
      logic       wk;
      logic       ack;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset;
   logic       ped_req;
   logic       ped_ack;
   logic       walk;
   logic [2:0] light_ns;
   logic [2:0] light_ew;
   logic [2:0] phase;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc_no = 0;

   traffic_phase_controller #(
      .T_GREEN  (4),
      .T_YELLOW (2),
      .T_ALLRED (1),
      .T_WALK   (3)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .ped_req  (ped_req),
      .ped_ack  (ped_ack),
      .walk     (walk),
      .light_ns (light_ns),
      .light_ew (light_ew),
      .phase    (phase)
   );

   always #5 clock = ~clock;

   function automatic exp_t mk(input logic [2:0] st, input logic ack);
      exp_t e;
      e.ph  = st;
      e.ack = ack;
      e.wk  = (st == WLK);
      case (st)
         NSG:     begin e.ns = LG; e.ew = LR; end
         NSY:     begin e.ns = LY; e.ew = LR; end
         EWG:     begin e.ns = LR; e.ew = LG; end
         EWY:     begin e.ns = LR; e.ew = LY; end
         default: begin e.ns = LR; e.ew = LR; end
      endcase
      return e;
   endfunction

   // One clock: drive inputs, queue the state expected after the coming edge.
   task automatic cyc(input logic rst, input logic req, input logic [2:0] st, input logic ack);
      reset   = rst;
      ped_req = req;
      q.push_back(mk(st, ack));
      @(posedge clock);
      #1;
   endtask

   // n cycles of one phase; mask bit i drives ped_req on the i-th edge.
   task automatic seg(input logic [2:0] st, input int n, input logic [31:0] mask);
      for (int i = 0; i < n; i++) begin
         cyc(1'b0, mask[i], st, (st == WLK) && (i == 0));
      end
   endtask

   task automatic normal_period;
      seg(NSG, 4, NONE); seg(NSY, 2, NONE); seg(ARA, 1, NONE);
      seg(EWG, 4, NONE); seg(EWY, 2, NONE); seg(ARB, 1, NONE);
   endtask

   // Monitor: each cycle pop one expectation and compare, plus lamp safety.
   initial begin
      exp_t e, a;
      forever begin
         @(posedge clock);
         @(negedge clock);
         cyc_no++;
         if (q.size() > 0) begin
            e = q.pop_front();
            a = {phase, light_ns, light_ew, walk, ped_ack};
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL seq cycle %0d: got ph=%0d ns=%b ew=%b walk=%b ack=%b, need ph=%0d ns=%b ew=%b walk=%b ack=%b",
                        cyc_no, a.ph, a.ns, a.ew, a.wk, a.ack, e.ph, e.ns, e.ew, e.wk, e.ack);
            end
            checks++;
            if (!$onehot(light_ns) || !$onehot(light_ew) || (light_ns != LR && light_ew != LR)) begin
               errors++;
               $display("FAIL safety cycle %0d: got ns=%b ew=%b, need one-hot lamps with at least one RED",
                        cyc_no, light_ns, light_ew);
            end
         end
      end
   end

   initial begin
      int wait_cnt;
      reset   = 1'b1;
      ped_req = 1'b0;

      // Reset and a plain period.
      cyc(1'b1, 1'b0, ARB, 1'b0);
      cyc(1'b1, 1'b0, ARB, 1'b0);
      normal_period();

      // Single request pulse in NS green: walk after ALLRED_A, resume EW.
      seg(NSG, 4, 32'b0010); seg(NSY, 2, NONE); seg(ARA, 1, NONE);
      seg(WLK, 3, NONE);
      seg(EWG, 4, NONE); seg(EWY, 2, NONE); seg(ARB, 1, NONE);

      // Request in EW yellow: walk after ALLRED_B, resume NS.
      seg(NSG, 4, NONE); seg(NSY, 2, NONE); seg(ARA, 1, NONE);
      seg(EWG, 4, NONE); seg(EWY, 2, 32'b10); seg(ARB, 1, NONE);
      seg(WLK, 3, NONE);
      seg(NSG, 4, NONE); seg(NSY, 2, NONE); seg(ARA, 1, NONE);

      // Request held for 20 edges spanning two walks; none from walk-time requests.
      seg(EWG, 4, ALL); seg(EWY, 2, ALL); seg(ARB, 1, ALL);
      seg(WLK, 3, ALL);
      seg(NSG, 4, ALL); seg(NSY, 2, ALL); seg(ARA, 1, ALL);
      seg(WLK, 3, ALL);
      seg(EWG, 4, NONE); seg(EWY, 2, NONE); seg(ARB, 1, NONE);
      seg(NSG, 4, NONE); seg(NSY, 2, NONE); seg(ARA, 1, NONE);

      // Reset in the 2nd EW green cycle with a pending request: it must be dropped.
      seg(EWG, 2, ALL);
      cyc(1'b1, 1'b0, ARB, 1'b0);
      normal_period();
      seg(NSG, 1, NONE);

      wait_cnt = 0;
      while (q.size() > 0 && wait_cnt < 20) begin
         @(posedge clock);
         wait_cnt++;
      end
      @(negedge clock);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d expectations left, need 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
